// File: rtl/song_pkg.sv
// Shared definitions for the song note player.
// Purpose : note-word field positions, FSM state encoding, default tone
//           amplitude and small helpers that pull fields out of a note word.
// Ports   : none (package).
package song_pkg;

  // Note word layout
  localparam int END_BIT = 31;
  localparam int HP_MSB  = 23;
  localparam int HP_LSB  = 12;
  localparam int DUR_MSB = 11;
  localparam int DUR_LSB = 0;
  localparam int HP_W    = HP_MSB - HP_LSB + 1;
  localparam int DUR_W   = DUR_MSB - DUR_LSB + 1;

  // State encoding
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_FETCH_ENC = 2'd1;
  localparam logic [1:0] ST_PLAY_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_FETCH = ST_FETCH_ENC,
    ST_PLAY  = ST_PLAY_ENC
  } state_e;

  // Magnitude of the square-wave sample
  localparam logic signed [31:0] DEFAULT_AMPLITUDE = 32'sd10000000;

  function automatic logic note_is_end(input logic [31:0] word);
    return word[END_BIT];
  endfunction

  function automatic logic [HP_W-1:0] note_half_period(input logic [31:0] word);
    return word[HP_MSB:HP_LSB];
  endfunction

  function automatic logic [DUR_W-1:0] note_duration(input logic [31:0] word);
    return word[DUR_MSB:DUR_LSB];
  endfunction

endpackage

// File: rtl/square_tone_gen.sv
// Square-wave tone generator.
// Purpose : keeps the phase counter and phase bit of the current note and
//           turns them into a signed sample. The phase advances only on
//           accepted samples, so backpressure stretches time, not pitch.
// Ports   : clk, reset (async, active-high)
//           load        - restart the waveform at the positive half
//           accept      - one sample was consumed this cycle
//           half_period - samples per half cycle; 0 means silence
//           sample      - signed sample value (combinational from state)
module square_tone_gen
  import song_pkg::*;
#(
  parameter logic signed [31:0] AMPLITUDE = DEFAULT_AMPLITUDE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                accept,
  input  logic [HP_W-1:0]     half_period,
  output logic signed [31:0]  sample
);

  logic [HP_W-1:0] phase_cnt_r;
  logic [HP_W-1:0] phase_cnt_plus_s;
  logic            phase_r;

  assign phase_cnt_plus_s = phase_cnt_r + HP_W'(1);

  // Phase counter and phase bit; a rest leaves the waveform frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_cnt_r <= {HP_W{1'b0}};
      phase_r     <= 1'b1;
    end else if (load) begin
      phase_cnt_r <= {HP_W{1'b0}};
      phase_r     <= 1'b1;
    end else if (accept && (half_period != {HP_W{1'b0}})) begin
      if (phase_cnt_plus_s == half_period) begin
        phase_cnt_r <= {HP_W{1'b0}};
        phase_r     <= ~phase_r;
      end else begin
        phase_cnt_r <= phase_cnt_plus_s;
      end
    end
  end

  // Sample value from the registered phase.
  always_comb begin
    sample = 32'sd0;
    if (half_period == {HP_W{1'b0}}) begin
      sample = 32'sd0;
    end else if (phase_r) begin
      sample = AMPLITUDE;
    end else begin
      sample = -AMPLITUDE;
    end
  end

endmodule

// File: rtl/song_note_player.sv
// Song note player.
// Purpose : walks the song memory one note word at a time and, for each
//           note, pushes duration*TICK_SAMPLES square-wave (or silent)
//           samples into the audio controller through its
//           audio_out_allowed / write_audio_out handshake.
// Ports   : CLOCK_50, reset (async, active-high)
//           start / stop              - playback control pulses
//           mem_address / mem_q       - song memory read port
//           audio_out_allowed         - controller FIFO has room
//           write_audio_out           - sample push strobe
//           left/right_channel_audio_out - identical sample outputs
//           busy                      - not idle
//           done                      - one-cycle pulse on an END word
module song_note_player
  import song_pkg::*;
#(
  parameter int                 ADDR_W       = 8,
  parameter int                 READ_LATENCY = 1,
  parameter int                 TICK_SAMPLES = 480,
  parameter logic signed [31:0] AMPLITUDE    = DEFAULT_AMPLITUDE
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [31:0]       mem_q,
  input  logic              audio_out_allowed,
  output logic              write_audio_out,
  output logic [31:0]       left_channel_audio_out,
  output logic [31:0]       right_channel_audio_out,
  output logic              busy,
  output logic              done
);

  localparam int TICK_W = $clog2(TICK_SAMPLES + 1);
  localparam int WAIT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_SAMPLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY);

  state_e              state_r, state_next_s;
  logic [ADDR_W-1:0]   mem_address_r, addr_next_s;
  logic [WAIT_W-1:0]   wait_cnt_r, wait_next_s;
  logic [DUR_W-1:0]    dur_cnt_r, dur_next_s;
  logic [TICK_W-1:0]   tick_cnt_r, tick_next_s;
  logic [TICK_W-1:0]   tick_plus_s;
  logic [HP_W-1:0]     hp_r, hp_next_s;
  logic                done_r, done_next_s;
  logic                load_s;
  logic                accept_s;
  logic signed [31:0]  tone_sample_s;
  logic                unused_reserved_s;

  // Reserved note bits carry no meaning.
  assign unused_reserved_s = ^mem_q[30:24];

  assign accept_s    = (state_r == ST_PLAY) && audio_out_allowed;
  assign tick_plus_s = tick_cnt_r + TICK_W'(1);

  // FSM state register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and datapath next values; stop overrides everything.
  always_comb begin
    state_next_s = state_r;
    addr_next_s  = mem_address_r;
    wait_next_s  = wait_cnt_r;
    dur_next_s   = dur_cnt_r;
    tick_next_s  = tick_cnt_r;
    hp_next_s    = hp_r;
    done_next_s  = 1'b0;
    load_s       = 1'b0;
    if (stop) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_next_s = ST_FETCH;
            addr_next_s  = {ADDR_W{1'b0}};
            wait_next_s  = {WAIT_W{1'b0}};
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          // mem_q is valid READ_LATENCY edges after the address settled
          if (wait_cnt_r == WAIT_LAST) begin
            wait_next_s = {WAIT_W{1'b0}};
            if (note_is_end(mem_q)) begin
              state_next_s = ST_IDLE;
              done_next_s  = 1'b1;
            end else if (note_duration(mem_q) == {DUR_W{1'b0}}) begin
              state_next_s = ST_FETCH;
              addr_next_s  = mem_address_r + ADDR_W'(1);
            end else begin
              state_next_s = ST_PLAY;
              dur_next_s   = note_duration(mem_q);
              tick_next_s  = {TICK_W{1'b0}};
              hp_next_s    = note_half_period(mem_q);
              load_s       = 1'b1;
            end
          end else begin
            wait_next_s = wait_cnt_r + WAIT_W'(1);
          end
        end
        ST_PLAY: begin
          if (audio_out_allowed) begin
            if (tick_plus_s == TICK_LAST) begin
              tick_next_s = {TICK_W{1'b0}};
              dur_next_s  = dur_cnt_r - DUR_W'(1);
              // this accepted sample ends the note
              if (dur_cnt_r == DUR_W'(1)) begin
                state_next_s = ST_FETCH;
                addr_next_s  = mem_address_r + ADDR_W'(1);
                wait_next_s  = {WAIT_W{1'b0}};
              end else begin
                state_next_s = ST_PLAY;
              end
            end else begin
              tick_next_s = tick_plus_s;
            end
          end else begin
            tick_next_s = tick_cnt_r;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath registers: address, fetch wait, duration and tick counters.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      mem_address_r <= {ADDR_W{1'b0}};
      wait_cnt_r    <= {WAIT_W{1'b0}};
      dur_cnt_r     <= {DUR_W{1'b0}};
      tick_cnt_r    <= {TICK_W{1'b0}};
      hp_r          <= {HP_W{1'b0}};
      done_r        <= 1'b0;
    end else begin
      mem_address_r <= addr_next_s;
      wait_cnt_r    <= wait_next_s;
      dur_cnt_r     <= dur_next_s;
      tick_cnt_r    <= tick_next_s;
      hp_r          <= hp_next_s;
      done_r        <= done_next_s;
    end
  end

  square_tone_gen #(
    .AMPLITUDE (AMPLITUDE)
  ) u_tone (
    .clk         (CLOCK_50),
    .reset       (reset),
    .load        (load_s),
    .accept      (accept_s),
    .half_period (hp_r),
    .sample      (tone_sample_s)
  );

  assign mem_address             = mem_address_r;
  assign write_audio_out         = accept_s;
  assign left_channel_audio_out  = (state_r == ST_PLAY) ? tone_sample_s : 32'sd0;
  assign right_channel_audio_out = left_channel_audio_out;
  assign busy                    = (state_r != ST_IDLE);
  assign done                    = done_r;

endmodule

// File: tb/tb_song_note_player.sv
// Scoreboard bench for song_note_player with TICK_SAMPLES=4 and a
// 1-cycle registered song memory model.
module tb_song_note_player;

  localparam logic [31:0] A     = 32'd10000000;
  localparam logic [31:0] NA    = 32'd0 - A;
  localparam logic [31:0] W_END = 32'h8012_3456;  // END with junk fields
  localparam logic [31:0] W_N22 = 32'h7F00_2002;  // hp=2 dur=2, reserved set
  localparam logic [31:0] W_R01 = 32'h0000_0001;  // rest, dur=1
  localparam logic [31:0] W_SKP = 32'h0000_0000;  // dur=0
  localparam logic [31:0] W_N11 = 32'h0000_1001;  // hp=1 dur=1

  logic        CLOCK_50;
  logic        reset;
  logic        start;
  logic        stop;
  logic [7:0]  mem_address;
  logic [31:0] mem_q;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:255];
  logic [31:0] exp_q [$];
  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;

  song_note_player #(.ADDR_W(8), .READ_LATENCY(1), .TICK_SAMPLES(4)) dut (
    .CLOCK_50                (CLOCK_50),
    .reset                   (reset),
    .start                   (start),
    .stop                    (stop),
    .mem_address             (mem_address),
    .mem_q                   (mem_q),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .busy                    (busy),
    .done                    (done)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) mem_q <= mem[mem_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe, watches done pulses.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (write_audio_out) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("sample_left", left_channel_audio_out, e);
          check("sample_right", right_channel_audio_out, e);
          check("strobe_allowed", {31'd0, audio_out_allowed}, 32'd1);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_width", {31'd0, prev_done}, 32'd0);
      end
      prev_done = done;
    end
  end

  task automatic fill(input logic [31:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  task automatic push4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
  endtask

  task automatic pulse(input logic s, input logic p);
    @(posedge CLOCK_50); #1; start = s; stop = p;
    @(posedge CLOCK_50); #1; start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max && done_cnt == d0; i++) @(posedge CLOCK_50);
    #1;
    check(name, done_cnt - d0, 32'd1);
  endtask

  task automatic end_scene(input string name, input int n);
    check({name, "_count"}, strobe_cnt, n);
    check({name, "_qempty"}, exp_q.size(), 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  int n;
  int d_before;
  logic wrap_seen;
  logic [7:0] prev_addr;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; audio_out_allowed = 1'b1;
    fill(W_END);
    #3;
    check("rst_addr", {24'd0, mem_address}, 32'd0);
    check("rst_write", {31'd0, write_audio_out}, 32'd0);
    check("rst_sample", left_channel_audio_out, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(posedge CLOCK_50); #1; reset = 1'b0;

    // Note then END; a second start mid-note must be ignored
    mem[0] = W_N22; mem[1] = W_END;
    push4(A, A, NA, NA); push4(A, A, NA, NA);
    strobe_cnt = 0;
    pulse(1'b1, 1'b0);
    repeat (5) @(posedge CLOCK_50);
    pulse(1'b1, 1'b0);
    wait_done("note_done", 100);
    end_scene("note", 8);
    check("note_addr", {24'd0, mem_address}, 32'd1);

    // Rest note
    fill(W_END); mem[0] = W_R01;
    push4(32'd0, 32'd0, 32'd0, 32'd0);
    strobe_cnt = 0;
    pulse(1'b1, 1'b0);
    wait_done("rest_done", 100);
    end_scene("rest", 4);
    check("rest_addr", {24'd0, mem_address}, 32'd1);

    // Backpressure: allowed follows 1,0,0 repeating
    fill(W_END); mem[0] = W_N22;
    push4(A, A, NA, NA); push4(A, A, NA, NA);
    strobe_cnt = 0;
    d_before = done_cnt;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 200 && done_cnt == d_before; i++) begin
      @(posedge CLOCK_50); #1;
      audio_out_allowed = (i % 3 == 0);
    end
    audio_out_allowed = 1'b1;
    check("bp_done", done_cnt - d_before, 32'd1);
    end_scene("bp", 8);

    // Zero-duration skip
    fill(W_END); mem[0] = W_SKP; mem[1] = W_N11;
    push4(A, NA, A, NA);
    strobe_cnt = 0;
    pulse(1'b1, 1'b0);
    wait_done("skip_done", 100);
    end_scene("skip", 4);
    check("skip_addr", {24'd0, mem_address}, 32'd2);

    // Stop in the cycle of the third strobe
    fill(W_END); mem[0] = W_N22;
    exp_q.push_back(A); exp_q.push_back(A); exp_q.push_back(NA);
    strobe_cnt = 0; n = 0;
    d_before = done_cnt;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 50 && n < 3; i++) begin
      @(posedge CLOCK_50); #1;
      if (write_audio_out) n++;
    end
    stop = 1'b1;
    @(posedge CLOCK_50); #1; stop = 1'b0;
    check("stop_write", {31'd0, write_audio_out}, 32'd0);
    repeat (6) @(posedge CLOCK_50);
    #1;
    check("stop_nodone", done_cnt - d_before, 32'd0);
    end_scene("stop", 3);

    // start+stop together stays idle
    pulse(1'b1, 1'b1);
    check("startstop_busy", {31'd0, busy}, 32'd0);

    // Replay from address 0 with a fresh waveform
    push4(A, A, NA, NA); push4(A, A, NA, NA);
    strobe_cnt = 0;
    pulse(1'b1, 1'b0);
    wait_done("replay_done", 100);
    end_scene("replay", 8);

    // Async reset between edges mid-PLAY
    exp_q.push_back(A); exp_q.push_back(A);
    strobe_cnt = 0; n = 0;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(posedge CLOCK_50); #1;
      if (write_audio_out) n++;
    end
    @(negedge CLOCK_50); #2;
    reset = 1'b1;
    #1;
    check("arst_write", {31'd0, write_audio_out}, 32'd0);
    check("arst_sample", left_channel_audio_out, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_addr", {24'd0, mem_address}, 32'd0);
    @(posedge CLOCK_50); #1; reset = 1'b0;
    end_scene("arst", 2);

    // Address wrap: rest at 0, skips everywhere else, no END
    fill(W_SKP); mem[0] = W_R01;
    push4(32'd0, 32'd0, 32'd0, 32'd0); push4(32'd0, 32'd0, 32'd0, 32'd0);
    strobe_cnt = 0; n = 0; wrap_seen = 1'b0;
    pulse(1'b1, 1'b0);
    prev_addr = mem_address;
    for (int i = 0; i < 3000 && n < 8; i++) begin
      @(posedge CLOCK_50); #1;
      if (prev_addr == 8'd255 && mem_address == 8'd0) wrap_seen = 1'b1;
      prev_addr = mem_address;
      if (write_audio_out) n++;
    end
    stop = 1'b1;
    @(posedge CLOCK_50); #1; stop = 1'b0;
    check("wrap_seen", {31'd0, wrap_seen}, 32'd1);
    end_scene("wrap", 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
